// File: rtl/ssd_scan_driver.sv
// Four-digit common-anode 7-segment scan driver with a free-running double-dabble converter.
// Optional leading-zero blanking: define SSD_LZ_BLANK_EN.
module ssd_scan_driver #(
  parameter int unsigned REFRESH_BITS = 20,
  parameter int unsigned NUM_W        = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM_W-1:0] num,
  output logic [3:0]       Anode,
  output logic [6:0]       LED_out,
  output logic [15:0]      bcd_out,
  output logic             conv_done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                  state, state_nx;
  logic [28:0]             sr, sr_nx;
  logic [3:0]              cnt, cnt_nx;
  logic [15:0]             bcd_nx;
  logic                    done_nx;
  logic [15:0]             adj;
  logic [12:0]             num_ext;
  logic [REFRESH_BITS-1:0] refresh;
  logic [1:0]              sel;
  logic [3:0]              digit;
  logic [3:0]              anode_nx;
  logic [6:0]              seg_nx;
  logic                    blank;

  always_comb begin
    num_ext = '0;
    num_ext[NUM_W-1:0] = num;
  end

  always_comb begin
    state_nx = state;
    sr_nx    = sr;
    cnt_nx   = cnt;
    bcd_nx   = bcd_out;
    done_nx  = 1'b0;
    adj      = sr[28:13];
    for (int unsigned i = 0; i < 4; i++) begin
      if (sr[13+4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = sr[13+4*i +: 4] + 4'd3;
    end
    case (state)
      IDLE: begin
        sr_nx    = {16'b0, num_ext};
        cnt_nx   = '0;
        state_nx = SHIFT;
      end
      SHIFT: begin
        // add-3 correction on the BCD field, then shift the whole register left by one
        sr_nx  = {adj[14:0], sr[12:0], 1'b0};
        cnt_nx = cnt + 4'd1;
        if (cnt == 4'd12)
          state_nx = DONE;
      end
      DONE: begin
        bcd_nx   = sr[28:13];
        done_nx  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      bcd_out   <= '0;
      conv_done <= 1'b0;
    end else begin
      state     <= state_nx;
      sr        <= sr_nx;
      cnt       <= cnt_nx;
      bcd_out   <= bcd_nx;
      conv_done <= done_nx;
    end
  end

  assign sel = refresh[REFRESH_BITS-1 -: 2];

  always_comb begin
    digit    = bcd_out[3:0];
    anode_nx = 4'b1110;
    case (sel)
      2'd0: begin digit = bcd_out[15:12]; anode_nx = 4'b0111; end
      2'd1: begin digit = bcd_out[11:8];  anode_nx = 4'b1011; end
      2'd2: begin digit = bcd_out[7:4];   anode_nx = 4'b1101; end
      default: begin digit = bcd_out[3:0]; anode_nx = 4'b1110; end
    endcase
  end

  always_comb begin
    blank = 1'b0;
`ifdef SSD_LZ_BLANK_EN
    // a slot is blank when it and every higher digit are zero; ones is never blank
    case (sel)
      2'd0:    blank = (bcd_out[15:12] == 4'd0);
      2'd1:    blank = (bcd_out[15:8]  == 8'd0);
      2'd2:    blank = (bcd_out[15:4]  == 12'd0);
      default: blank = 1'b0;
    endcase
`endif
  end

  always_comb begin
    case (digit)
      4'd0:    seg_nx = 7'b0000001;
      4'd1:    seg_nx = 7'b1001111;
      4'd2:    seg_nx = 7'b0010010;
      4'd3:    seg_nx = 7'b0000110;
      4'd4:    seg_nx = 7'b1001100;
      4'd5:    seg_nx = 7'b0100100;
      4'd6:    seg_nx = 7'b0100000;
      4'd7:    seg_nx = 7'b0001111;
      4'd8:    seg_nx = 7'b0000000;
      4'd9:    seg_nx = 7'b0000100;
      default: seg_nx = 7'b1111111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh <= '0;
      Anode   <= '1;
      LED_out <= '1;
    end else begin
      refresh <= refresh + 1'b1;
      Anode   <= blank ? 4'b1111 : anode_nx;
      LED_out <= blank ? 7'b1111111 : seg_nx;
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench for ssd_scan_driver; the reference model works in decimal arithmetic.
module tb_ssd_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] num = '0;
  logic [3:0]  Anode;
  logic [6:0]  LED_out;
  logic [15:0] bcd_out;
  logic        conv_done;

  int total = 0;
  int bad   = 0;
  int unsigned k = 0;
  int c;

  logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
  int dir_vals [7] = '{1234, 8191, 0, 9, 5, 4, 999};
  int lim [3] = '{1000, 100, 10};

  ssd_scan_driver #(.REFRESH_BITS(4), .NUM_W(13)) dut (
    .clk(clk), .rst(rst), .num(num), .Anode(Anode),
    .LED_out(LED_out), .bcd_out(bcd_out), .conv_done(conv_done)
  );

  always #5 clk = ~clk;

  // edges since reset release; the DUT refresh counter should equal this
  always @(posedge clk) begin
    if (rst) k = 0;
    else     k = k + 1;
  end

  function automatic logic [15:0] to_bcd(input int n);
    return 16'(((n / 1000) << 12) | (((n / 100) % 10) << 8) | (((n / 10) % 10) << 4) | (n % 10));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!conv_done && cycles < 40);
    if (!conv_done) chk("done_timeout", {31'b0, conv_done}, 32'd1);
  endtask

  task automatic check_scan(input int n);
    int p, d;
    logic [3:0] ea;
    logic [6:0] el;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      p  = int'(((k - 1) % 16) / 4);
      d  = (p == 0) ? n / 1000 : (p == 1) ? (n / 100) % 10 : (p == 2) ? (n / 10) % 10 : n % 10;
      ea = ~(4'b1000 >> p);
      el = seg_tab[d];
`ifdef SSD_LZ_BLANK_EN
      if (p < 3 && n < lim[p]) begin
        ea = 4'b1111;
        el = 7'b1111111;
      end
`endif
      chk("scan_anode", {28'b0, Anode}, {28'b0, ea});
      chk("scan_led", {25'b0, LED_out}, {25'b0, el});
    end
  endtask

  initial begin
    // reset held three cycles
    repeat (3) @(negedge clk);
    chk("rst_anode", {28'b0, Anode}, 32'hF);
    chk("rst_led", {25'b0, LED_out}, 32'h7F);
    chk("rst_bcd", {16'b0, bcd_out}, 32'h0);
    chk("rst_done", {31'b0, conv_done}, 32'h0);
    rst = 1'b0;
    wait_done(c);
    chk("first_latency", c, 15);
    chk("first_bcd", {16'b0, bcd_out}, 32'h0);
    @(negedge clk);
    chk("done_pulse", {31'b0, conv_done}, 32'h0);
    wait_done(c);

    // directed values, each followed by a full scan sweep
    foreach (dir_vals[i]) begin
      num = 13'(dir_vals[i]);
      wait_done(c);
      chk("dir_latency", c, 15);
      chk("dir_bcd", {16'b0, bcd_out}, {16'b0, to_bcd(dir_vals[i])});
      check_scan(dir_vals[i]);
      wait_done(c);
      chk("dir_bcd_hold", {16'b0, bcd_out}, {16'b0, to_bcd(dir_vals[i])});
    end

    // num changes three cycles after it was sampled
    num = 13'd1234;
    wait_done(c);
    repeat (3) @(negedge clk);
    num = 13'd4321;
    wait_done(c);
    chk("chg_latency", c, 12);
    chk("chg_old", {16'b0, bcd_out}, 32'h1234);
    wait_done(c);
    chk("chg_latency2", c, 15);
    chk("chg_new", {16'b0, bcd_out}, 32'h4321);

    // reset mid-conversion
    num = 13'd5555;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_bcd", {16'b0, bcd_out}, 32'h0);
    chk("midrst_done", {31'b0, conv_done}, 32'h0);
    chk("midrst_anode", {28'b0, Anode}, 32'hF);
    rst = 1'b0;
    wait_done(c);
    chk("midrst_latency", c, 15);
    chk("midrst_bcd2", {16'b0, bcd_out}, 32'h5555);

    // leading-zero behaviour
    num = 13'd7;
    wait_done(c);
    wait_done(c);
    chk("seven_bcd", {16'b0, bcd_out}, 32'h0007);
    check_scan(7);
    wait_done(c);

    // random values
    for (int i = 0; i < 12; i++) begin
      int r;
      r = int'($urandom_range(0, 8191));
      num = 13'(r);
      wait_done(c);
      chk("rnd_latency", c, 15);
      chk("rnd_bcd", {16'b0, bcd_out}, {16'b0, to_bcd(r)});
    end
    check_scan(int'(num));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
